alu_regfile: RTL and testbench

ALU_REGFILE -- requirements
Module: alu_regfile

---
 rtl/alu_regfile_pkg.sv | 35 +++
 rtl/shift_add_mul.sv | 55 +++++
 rtl/alu_regfile.sv | 192 +++++++++++++++++++
 tb/tb_alu_regfile.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_regfile_pkg.sv
// Shared types for alu_regfile: opcode encoding, {V,N,C,Z} flag struct and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OpNop  = 4'h0,
        OpLoad = 4'h1,
        OpCopy = 4'h2,
        OpSwap = 4'h3,
        OpAdd  = 4'h4,
        OpSub  = 4'h5,
        OpAnd  = 4'h6,
        OpOr   = 4'h7,
        OpXor  = 4'h8,
        OpNot  = 4'h9,
        OpShl  = 4'hA,
        OpShr  = 4'hB,
        OpClr  = 4'hC,
        OpMul  = 4'hD,
        OpCmp  = 4'hE,
        OpRsvd = 4'hF
    } op_e;

    typedef struct packed {
        logic v;
        logic n;
        logic c;
        logic z;
    } flags_t;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// o_product is the combinational next accumulator so the caller can commit on the done edge.
module shift_add_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_acc    <= '0;
            r_mplier <= i_b;
            r_cnt    <= CW'(WIDTH);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_cnt == CW'(1));
    assign o_product = w_acc_next;

endmodule

// File: rtl/alu_regfile.sv
// Register file with single-cycle ALU and valid/ready command port.
// Define ALU_REGFILE_MUL_EN to add the multi-cycle MUL opcode; otherwise opcode D is illegal.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 4,
    localparam int unsigned RW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [RW-1:0]    cmd_dst,
    input  logic [RW-1:0]    cmd_src,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [RW-1:0]    rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       flags,
    output logic             res_err
);

    logic [WIDTH-1:0] r_regs [NREGS];
    flags_t           r_flags;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_valid;
    logic             r_res_err;

    op_e              w_op;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_wdata;
    logic             w_wr_d;
    logic             w_wr_s;
    logic             w_res_upd;
    logic             w_flag_upd;
    logic             w_err;
    logic             w_mul_start;
    flags_t           w_nf;

    assign w_op     = op_e'(cmd_op);
    assign w_accept = cmd_valid && cmd_ready;
    assign w_a      = r_regs[cmd_dst];
    assign w_b      = r_regs[cmd_src];
    assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff   = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_wdata     = '0;
        w_wr_d      = 1'b0;
        w_wr_s      = 1'b0;
        w_res_upd   = 1'b0;
        w_flag_upd  = 1'b0;
        w_err       = 1'b0;
        w_mul_start = 1'b0;
        w_nf        = '0;
        case (w_op)
            OpNop: ;
            OpLoad: begin w_wdata = cmd_data; w_wr_d = 1'b1; w_res_upd = 1'b1; end
            OpCopy: begin w_wdata = w_b; w_wr_d = 1'b1; w_res_upd = 1'b1; end
            OpSwap: begin w_wdata = w_b; w_wr_d = 1'b1; w_wr_s = 1'b1; w_res_upd = 1'b1; end
            OpAdd: begin
                w_wdata = w_sum[WIDTH-1:0];
                w_wr_d  = 1'b1; w_res_upd = 1'b1; w_flag_upd = 1'b1;
                w_nf.c  = w_sum[WIDTH];
                w_nf.v  = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            OpSub, OpCmp: begin
                w_wdata = w_diff[WIDTH-1:0];
                w_wr_d  = (w_op == OpSub); w_res_upd = 1'b1; w_flag_upd = 1'b1;
                w_nf.c  = w_diff[WIDTH];
                w_nf.v  = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            OpAnd: begin w_wdata = w_a & w_b; w_wr_d = 1'b1; w_res_upd = 1'b1; w_flag_upd = 1'b1; end
            OpOr:  begin w_wdata = w_a | w_b; w_wr_d = 1'b1; w_res_upd = 1'b1; w_flag_upd = 1'b1; end
            OpXor: begin w_wdata = w_a ^ w_b; w_wr_d = 1'b1; w_res_upd = 1'b1; w_flag_upd = 1'b1; end
            OpNot: begin w_wdata = ~w_a; w_wr_d = 1'b1; w_res_upd = 1'b1; w_flag_upd = 1'b1; end
            OpShl: begin
                w_wdata = {w_a[WIDTH-2:0], 1'b0};
                w_wr_d  = 1'b1; w_res_upd = 1'b1; w_flag_upd = 1'b1;
                w_nf.c  = w_a[WIDTH-1];
            end
            OpShr: begin
                w_wdata = {1'b0, w_a[WIDTH-1:1]};
                w_wr_d  = 1'b1; w_res_upd = 1'b1; w_flag_upd = 1'b1;
                w_nf.c  = w_a[0];
            end
            OpClr: begin w_wdata = '0; w_wr_d = 1'b1; w_res_upd = 1'b1; end
`ifdef ALU_REGFILE_MUL_EN
            OpMul: w_mul_start = 1'b1;
`else
            OpMul: w_err = 1'b1;
`endif
            default: w_err = 1'b1;
        endcase
        w_nf.z = (w_wdata == '0);
        w_nf.n = w_wdata[WIDTH-1];
    end

`ifdef ALU_REGFILE_MUL_EN
    state_e             r_state;
    state_e             w_state_d;
    logic [RW-1:0]      r_mul_dst;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    flags_t             w_mul_flags;

    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_start   (w_accept && w_mul_start),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: if (w_accept && w_mul_start) w_state_d = StMul;
            StMul:  if (w_mul_done) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        w_mul_flags.v = 1'b0;
        w_mul_flags.n = w_product[WIDTH-1];
        w_mul_flags.c = |w_product[2*WIDTH-1:WIDTH];
        w_mul_flags.z = (w_product[WIDTH-1:0] == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_mul_dst <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept && w_mul_start) r_mul_dst <= cmd_dst;
        end
    end

    assign cmd_ready = reset_n && (r_state == StIdle) && !w_mul_busy;
`else
    assign cmd_ready = reset_n;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_flags     <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            if (w_accept && !w_mul_start) begin
                r_res_valid <= 1'b1;
                r_res_err   <= w_err;
                // SWAP with d==s writes the same value twice, so the register is unchanged.
                if (w_wr_d) r_regs[cmd_dst] <= w_wdata;
                if (w_wr_s) r_regs[cmd_src] <= w_a;
                if (w_res_upd) r_res_data <= w_wdata;
                if (w_flag_upd) r_flags <= w_nf;
            end
`ifdef ALU_REGFILE_MUL_EN
            if (w_mul_done) begin
                r_regs[r_mul_dst] <= w_product[WIDTH-1:0];
                r_res_data        <= w_product[WIDTH-1:0];
                r_flags           <= w_mul_flags;
                r_res_valid       <= 1'b1;
                r_res_err         <= 1'b0;
            end
`endif
        end
    end

    assign rd_data   = r_regs[rd_sel];
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign flags     = r_flags;
    assign res_err   = r_res_err;

endmodule

// File: tb/tb_alu_regfile.sv
// Scoreboard bench for alu_regfile: directed commands push expected results, a monitor checks them.
module tb_alu_regfile;

    localparam logic [3:0] NOP = 4'h0, LOAD = 4'h1, COPY = 4'h2, SWAP = 4'h3, ADD = 4'h4;
    localparam logic [3:0] SUB = 4'h5, AND = 4'h6, OR = 4'h7, XOR = 4'h8, NOT = 4'h9;
    localparam logic [3:0] SHL = 4'hA, SHR = 4'hB, CLR = 4'hC, MUL = 4'hD, CMP = 4'hE;
    localparam logic [3:0] RSV = 4'hF;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src;
    logic [7:0] cmd_data;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
    logic       res_valid;
    logic [7:0] res_data;
    logic [3:0] flags;
    logic       res_err;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] data;
        logic [3:0] fl;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] next_id = 8'd0;
    logic [3:0] fl;

    alu_regfile #(
        .WIDTH (8),
        .NREGS (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_src   (cmd_src),
        .cmd_data  (cmd_data),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .res_valid (res_valid),
        .res_data  (res_data),
        .flags     (flags),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rd_check(input string name, input logic [1:0] idx, input logic [7:0] exp);
        rd_sel = idx;
        #1;
        check(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    // Offers one command, waits (bounded) for acceptance, returns 1 time unit after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s,
                         input logic [7:0] data, input logic [7:0] e_data,
                         input logic [3:0] e_fl, input logic e_err, input bit expect_res);
        int n;
        exp_t e;
        cmd_op    = op;
        cmd_dst   = d;
        cmd_src   = s;
        cmd_data  = data;
        cmd_valid = 1'b1;
        if (expect_res) begin
            e.id   = next_id;
            e.data = e_data;
            e.fl   = e_fl;
            e.err  = e_err;
            sb_q.push_back(e);
        end
        next_id++;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: cmd %0d got ready=0 expected ready=1", next_id - 8'd1);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (res_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res_valid: got res_valid=1 expected 0");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("res_data[%0d]", e.id), {24'd0, res_data}, {24'd0, e.data});
                check($sformatf("flags[%0d]", e.id), {28'd0, flags}, {28'd0, e.fl});
                check($sformatf("res_err[%0d]", e.id), {31'd0, res_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_dst   = 2'd0;
        cmd_src   = 2'd0;
        cmd_data  = 8'h00;
        rd_sel    = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, cmd_ready}, 32'd0);
        check("reset_valid", {31'd0, res_valid}, 32'd0);
        check("reset_res_data", {24'd0, res_data}, 32'd0);
        check("reset_flags", {28'd0, flags}, 32'd0);
        for (int i = 0; i < 4; i++) rd_check($sformatf("reset_r%0d", i), 2'(i), 8'h00);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", {31'd0, cmd_ready}, 32'd1);

        // {V,N,C,Z}: 0x7F + 0x01 overflows to 0x80
        issue(LOAD, 2'd0, 2'd0, 8'h7F, 8'h7F, 4'b0000, 1'b0, 1'b1);
        issue(LOAD, 2'd1, 2'd0, 8'h01, 8'h01, 4'b0000, 1'b0, 1'b1);
        issue(ADD, 2'd0, 2'd1, 8'h00, 8'h80, 4'b1100, 1'b0, 1'b1);
        check("add_valid_next_cycle", {31'd0, res_valid}, 32'd1);
        rd_check("add_r0", 2'd0, 8'h80);

        issue(LOAD, 2'd0, 2'd0, 8'h05, 8'h05, 4'b1100, 1'b0, 1'b1);
        issue(LOAD, 2'd1, 2'd0, 8'h05, 8'h05, 4'b1100, 1'b0, 1'b1);
        issue(CMP, 2'd0, 2'd1, 8'h00, 8'h00, 4'b0001, 1'b0, 1'b1);
        rd_check("cmp_r0_kept", 2'd0, 8'h05);
        issue(LOAD, 2'd2, 2'd0, 8'h06, 8'h06, 4'b0001, 1'b0, 1'b1);
        issue(SUB, 2'd0, 2'd2, 8'h00, 8'hFF, 4'b0110, 1'b0, 1'b1);
        rd_check("sub_r0", 2'd0, 8'hFF);

        issue(RSV, 2'd0, 2'd1, 8'h33, 8'hFF, 4'b0110, 1'b1, 1'b1);
        rd_check("rsv_r0", 2'd0, 8'hFF);
        rd_check("rsv_r1", 2'd1, 8'h05);

`ifdef ALU_REGFILE_MUL_EN
        issue(LOAD, 2'd2, 2'd0, 8'h0C, 8'h0C, 4'b0110, 1'b0, 1'b1);
        issue(LOAD, 2'd3, 2'd0, 8'h0B, 8'h0B, 4'b0110, 1'b0, 1'b1);
        issue(MUL, 2'd2, 2'd3, 8'h00, 8'h84, 4'b0100, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("mul_busy_ready_%0d", i), {31'd0, cmd_ready}, 32'd0);
            check($sformatf("mul_busy_valid_%0d", i), {31'd0, res_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("mul_done_ready", {31'd0, cmd_ready}, 32'd1);
        check("mul_done_valid", {31'd0, res_valid}, 32'd1);
        rd_check("mul_r2", 2'd2, 8'h84);
        issue(LOAD, 2'd2, 2'd0, 8'h10, 8'h10, 4'b0100, 1'b0, 1'b1);
        issue(LOAD, 2'd3, 2'd0, 8'h10, 8'h10, 4'b0100, 1'b0, 1'b1);
        issue(MUL, 2'd2, 2'd3, 8'h00, 8'h00, 4'b0011, 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        rd_check("mul_r2_wrap", 2'd2, 8'h00);
        fl = 4'b0011;
`else
        issue(MUL, 2'd0, 2'd1, 8'h00, 8'hFF, 4'b0110, 1'b1, 1'b1);
        check("mul_dis_ready", {31'd0, cmd_ready}, 32'd1);
        rd_check("mul_dis_r0", 2'd0, 8'hFF);
        rd_check("mul_dis_r1", 2'd1, 8'h05);
        fl = 4'b0110;
`endif

        issue(LOAD, 2'd0, 2'd0, 8'hAA, 8'hAA, fl, 1'b0, 1'b1);
        issue(LOAD, 2'd3, 2'd0, 8'h55, 8'h55, fl, 1'b0, 1'b1);
        issue(SWAP, 2'd0, 2'd3, 8'h00, 8'h55, fl, 1'b0, 1'b1);
        issue(XOR, 2'd0, 2'd3, 8'h00, 8'hFF, 4'b0100, 1'b0, 1'b1);
        check("xor_back_to_back_valid", {31'd0, res_valid}, 32'd1);
        rd_check("xor_r0", 2'd0, 8'hFF);
        rd_check("swap_r3", 2'd3, 8'hAA);

        issue(NOP, 2'd2, 2'd1, 8'h77, 8'hFF, 4'b0100, 1'b0, 1'b1);
        issue(COPY, 2'd1, 2'd1, 8'h00, 8'h05, 4'b0100, 1'b0, 1'b1);
        rd_check("copy_same_r1", 2'd1, 8'h05);
        issue(SWAP, 2'd1, 2'd1, 8'h00, 8'h05, 4'b0100, 1'b0, 1'b1);
        rd_check("swap_same_r1", 2'd1, 8'h05);
        issue(SHL, 2'd0, 2'd0, 8'h00, 8'hFE, 4'b0110, 1'b0, 1'b1);
        issue(SHR, 2'd3, 2'd0, 8'h00, 8'h55, 4'b0000, 1'b0, 1'b1);
        issue(NOT, 2'd3, 2'd0, 8'h00, 8'hAA, 4'b0100, 1'b0, 1'b1);
        issue(CLR, 2'd3, 2'd0, 8'h00, 8'h00, 4'b0100, 1'b0, 1'b1);
        rd_check("clr_r3", 2'd3, 8'h00);
        issue(OR, 2'd3, 2'd1, 8'h00, 8'h05, 4'b0000, 1'b0, 1'b1);
        issue(AND, 2'd0, 2'd1, 8'h00, 8'h04, 4'b0000, 1'b0, 1'b1);
        issue(LOAD, 2'd2, 2'd0, 8'hFF, 8'hFF, 4'b0000, 1'b0, 1'b1);
        issue(ADD, 2'd0, 2'd2, 8'h00, 8'h03, 4'b0010, 1'b0, 1'b1);
        rd_check("add_carry_r0", 2'd0, 8'h03);

`ifdef ALU_REGFILE_MUL_EN
        issue(LOAD, 2'd2, 2'd0, 8'h03, 8'h03, 4'b0010, 1'b0, 1'b1);
        issue(LOAD, 2'd3, 2'd0, 8'h03, 8'h03, 4'b0010, 1'b0, 1'b1);
        issue(MUL, 2'd2, 2'd3, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
`else
        repeat (2) @(posedge clk);
        #1;
`endif
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_abort", {31'd0, cmd_ready}, 32'd1);
        check("flags_after_abort", {28'd0, flags}, 32'd0);
        check("res_data_after_abort", {24'd0, res_data}, 32'd0);
        for (int i = 0; i < 4; i++) rd_check($sformatf("abort_r%0d", i), 2'(i), 8'h00);
        repeat (12) @(posedge clk);
        #1;
        check("pending_results", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
